// File: rtl/sd_dat_reader.sv
// sd_dat_reader: SD DAT-line block receiver.
//
// Receives one data block on 1 or 4 DAT lines. The payload is packed
// big-endian into 32-bit words and pushed into an internal FIFO. The CRC16
// of each active line and the end bit are checked on every block.
//
// Ports:
//   clk, resetn         system clock; synchronous active-low reset
//   dat_in, new_sd_clk  sampled DAT levels, qualified by a one-clk strobe
//                       that fires once per bus clock
//   start_req, abort    start a read; cancel the read and flush the FIFO
//   wide_mode           use 4 lines (only honoured when NUM_LINES == 4)
//   block_len           payload bytes per block, latched at start_req
//   out_data/valid/ready  FIFO head word and valid/ready pop handshake
//   busy, done          not idle; one-clk pulse when a read completes
//   err_*               sticky error flags, cleared by the next start
//
// Optional feature (macro SD_DAT_MULTI_BLOCK_EN): adds block_count[15:0].
// The block then receives block_count blocks back to back, ORs the error
// flags across all of them and pulses done once at the end.
module sd_dat_reader #(
  parameter int  NUM_LINES       = 4,
  parameter int  MAX_BLOCK_BYTES = 512,
  parameter int  FIFO_DEPTH      = 16,
  parameter int  TIMEOUT_CLKS    = 65536,
  localparam int BL_W            = $clog2(MAX_BLOCK_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_LINES-1:0] dat_in,
  input  logic                 new_sd_clk,
  input  logic                 start_req,
  input  logic                 abort,
  input  logic                 wide_mode,
  input  logic [BL_W-1:0]      block_len,
`ifdef SD_DAT_MULTI_BLOCK_EN
  input  logic [15:0]          block_count,
`endif
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err_crc,
  output logic                 err_end_bit,
  output logic                 err_start_bit,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  // The DATA/CRC counter must hold both block_len*8 and 16.
  localparam int CW = (BL_W + 3 > 5) ? BL_W + 3 : 5;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_COLLECT
  } state_t;

  state_t state, state_n;

  logic [BL_W-1:0]            blen_q;
  logic                       wide_q;
  logic [TW-1:0]              tmr;
  logic [CW-1:0]              cnt, nclk;
  logic [31:0]                word, word_sh, push_data;
  logic [5:0]                 nbits, nbits_n;
  logic [NUM_LINES-1:0][15:0] crc, crc_step;
  logic [NUM_LINES-1:0]       act;
  logic [3:0]                 dat4;

  logic accept, start_seen, tmo, data_last, crc_last, end_tick;
  logic shift_crc, crc_bad, end_bad, more_blocks, restart;
  logic data_tick, push, wr_ok, pop, overrun, empty, full;

  logic [AW:0]  wr_ptr, rd_ptr, rd_n;
  logic [31:0]  mem [FIFO_DEPTH];

  // Zero-extended view so 4-line indexing stays legal when NUM_LINES == 1.
  assign dat4 = 4'(dat_in);
  assign act  = wide_q ? {NUM_LINES{1'b1}} : NUM_LINES'(1);
  assign nclk = wide_q ? CW'({blen_q, 1'b0}) : CW'({blen_q, 3'b000});

  assign accept     = (state == S_IDLE) && start_req && !abort;
  assign start_seen = (state == S_WAIT) && new_sd_clk && !dat4[0];
  assign tmo        = (state == S_WAIT) && new_sd_clk && dat4[0] &&
                      (tmr == TW'(TIMEOUT_CLKS - 1));
  assign data_tick  = (state == S_DATA) && new_sd_clk;
  assign data_last  = data_tick && (cnt == nclk - 1'b1);
  assign crc_last   = (state == S_CRC) && new_sd_clk && (cnt == CW'(15));
  assign end_tick   = (state == S_END) && new_sd_clk;
  assign shift_crc  = new_sd_clk && ((state == S_DATA) || (state == S_CRC));
  assign end_bad    = |(act & ~dat_in);
  assign restart    = end_tick && more_blocks;

`ifdef SD_DAT_MULTI_BLOCK_EN
  logic [15:0] blk_left;

  assign more_blocks = (blk_left > 16'd1);

  always_ff @(posedge clk) begin
    if (!resetn)      blk_left <= '0;
    else if (accept)  blk_left <= (block_count == 16'd0) ? 16'd1 : block_count;
    else if (restart) blk_left <= blk_left - 16'd1;
  end
`else
  assign more_blocks = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start_req)  state_n = S_WAIT;
        S_WAIT:    if (start_seen) state_n = S_DATA;
                   else if (tmo)   state_n = S_COLLECT;
        S_DATA:    if (data_last)  state_n = S_CRC;
        S_CRC:     if (crc_last)   state_n = S_END;
        S_END:     if (end_tick)   state_n = more_blocks ? S_WAIT : S_COLLECT;
        S_COLLECT: state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_COLLECT) && !abort;

  // ---------------- Latches and counters ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      blen_q <= '0;
      wide_q <= 1'b0;
      tmr    <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        blen_q <= block_len;
        wide_q <= wide_mode && (NUM_LINES == 4);
      end
      if (accept || restart)                 tmr <= '0;
      else if (state == S_WAIT && new_sd_clk) tmr <= tmr + 1'b1;
      if (start_seen)     cnt <= '0;
      else if (shift_crc) cnt <= (data_last || crc_last) ? '0 : cnt + 1'b1;
    end
  end

  // ---------------- Per-line CRC16 (x^16+x^12+x^5+1, init 0) ----------------
  // The received CRC is shifted through the same register, so a good line
  // ends at zero.
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_crc
    assign crc_step[i] = {crc[i][14:0], 1'b0} ^
                         ({16{dat_in[i] ^ crc[i][15]}} & 16'h1021);
  end

  always_ff @(posedge clk) begin
    if (!resetn || start_seen) crc <= '0;
    else if (shift_crc)        crc <= crc_step;
  end

  // The last CRC bit is judged from crc_step so no extra cycle is needed.
  always_comb begin
    crc_bad = 1'b0;
    for (int i = 0; i < NUM_LINES; i++)
      if (act[i] && (crc_step[i] != 16'h0)) crc_bad = 1'b1;
  end

  // ---------------- Word packing ----------------
  assign word_sh   = wide_q ? {word[27:0], dat4} : {word[30:0], dat4[0]};
  assign nbits_n   = nbits + (wide_q ? 6'd4 : 6'd1);
  // A short final word is left-aligned so its first byte sits in [31:24].
  assign push_data = word_sh << (6'd32 - nbits_n);
  assign push      = data_tick && ((nbits_n == 6'd32) || data_last) && !abort;

  always_ff @(posedge clk) begin
    if (!resetn || start_seen) begin
      word  <= '0;
      nbits <= '0;
    end else if (data_tick) begin
      if ((nbits_n == 6'd32) || data_last) begin
        word  <= '0;
        nbits <= '0;
      end else begin
        word  <= word_sh;
        nbits <= nbits_n;
      end
    end
  end

  // ---------------- Output FIFO ----------------
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign out_valid = !empty;
  assign pop       = !empty && out_ready;
  // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
  assign wr_ok     = push && (!full || pop);
  assign overrun   = push && full && !pop;
  assign rd_n      = rd_ptr + (AW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // out_data is a registered copy of the head; it is reloaded whenever the
  // head moves, bypassing the word being written if that becomes the head.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_data <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rd_ptr <= rd_n;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (empty && wr_ok))
        out_data <= (wr_ok && (rd_n[AW-1:0] == wr_ptr[AW-1:0])) ?
                    push_data : mem[rd_n[AW-1:0]];
    end
  end

  // ---------------- Error flags ----------------
  always_ff @(posedge clk) begin
    if (!resetn || accept) begin
      err_crc       <= 1'b0;
      err_end_bit   <= 1'b0;
      err_start_bit <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else if (!abort) begin
      if (start_seen && wide_q && (|dat4[3:1])) err_start_bit <= 1'b1;
      if (tmo)                                  err_timeout   <= 1'b1;
      if (crc_last && crc_bad)                  err_crc       <= 1'b1;
      if (end_tick && end_bad)                  err_end_bit   <= 1'b1;
      if (overrun)                              err_overrun   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_dat_reader.sv
// Self-checking bench for sd_dat_reader. Blocks are built from byte lists;
// per-line bit streams, CRCs (polynomial long division) and expected FIFO
// words are derived from the bytes in the bench.
module tb_sd_dat_reader;
  localparam int NL = 4, MB = 512, FD = 16, TO = 64;
  localparam int BW = $clog2(MB + 1);

  logic          clk = 1'b0, resetn = 1'b0, new_sd_clk = 1'b0;
  logic          start_req = 1'b0, abort = 1'b0, wide_mode = 1'b0, out_ready = 1'b1;
  logic [NL-1:0] dat_in = '1;
  logic [BW-1:0] block_len = '0;
  logic [31:0]   out_data;
  logic          out_valid, busy, done;
  logic          err_crc, err_end_bit, err_start_bit, err_timeout, err_overrun;
`ifdef SD_DAT_MULTI_BLOCK_EN
  logic [15:0]   block_count = 16'd1;
`endif

  int n_pass = 0, n_fail = 0, n_total = 0, done_cnt = 0;
  logic [7:0]  tx[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  bit          ln [4][4096];

  always #5 clk = ~clk;

  sd_dat_reader #(.NUM_LINES(NL), .MAX_BLOCK_BYTES(MB), .FIFO_DEPTH(FD),
                  .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .resetn(resetn), .dat_in(dat_in), .new_sd_clk(new_sd_clk),
    .start_req(start_req), .abort(abort), .wide_mode(wide_mode),
    .block_len(block_len),
`ifdef SD_DAT_MULTI_BLOCK_EN
    .block_count(block_count),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err_crc(err_crc), .err_end_bit(err_end_bit),
    .err_start_bit(err_start_bit), .err_timeout(err_timeout),
    .err_overrun(err_overrun));

  // Observe pops and done away from the active edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // errs = {crc, end, start, timeout, overrun}
  task automatic check_errs(input string tag, input logic [4:0] e);
    check({tag, " errs"}, {27'd0, err_crc, err_end_bit, err_start_bit, err_timeout, err_overrun},
          {27'd0, e});
  endtask

  task automatic sd_tick(input logic [3:0] v);
    dat_in = v; new_sd_clk = 1'b1;
    @(posedge clk); #1;
    new_sd_clk = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int len, input bit w);
    block_len = BW'(len); wide_mode = w; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
  endtask

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_model(input int line, input int n);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < n + 16; i++) begin
      r = {r[15:0], (i < n) ? ln[line][i] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic add_exp();
    logic [31:0] w;
    for (int i = 0; i < tx.size(); i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], (i + j < tx.size()) ? tx[i + j] : 8'h00};
      exp_q.push_back(w);
    end
  endtask

  // Sends tx as one block: idle, start, data, CRC (optionally corrupted), end.
  task automatic send_frame(input bit w, input int flip_line, input logic end_v,
                            input logic [3:0] start_v);
    int nb;
    logic [15:0] c [4];
    logic [3:0] v;
    nb = w ? tx.size() * 2 : tx.size() * 8;
    for (int i = 0; i < tx.size(); i++)
      for (int b = 0; b < 8; b++)
        if (w) ln[b % 4][2 * i + ((b < 4) ? 1 : 0)] = tx[i][b];
        else   ln[0][8 * i + 7 - b] = tx[i][b];
    for (int k = 0; k < 4; k++) c[k] = crc_model(k, nb);
    sd_tick(4'hF); sd_tick(4'hF);
    sd_tick(start_v);
    for (int t = 0; t < nb; t++) begin
      v = 4'hF;
      if (w) v = {ln[3][t], ln[2][t], ln[1][t], ln[0][t]};
      else   v[0] = ln[0][t];
      sd_tick(v);
    end
    for (int b = 15; b >= 0; b--) begin
      v = 4'hF;
      for (int k = 0; k < (w ? 4 : 1); k++) v[k] = c[k][b] ^ ((k == flip_line) && (b == 7));
      sd_tick(v);
    end
    sd_tick(w ? {4{end_v}} : {3'b111, end_v});
    sd_tick(4'hF);
  endtask

  task automatic check_words(input string tag, input int base);
    check({tag, " word count"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      check({tag, " word"}, got[base + i], exp_q[i]);
  endtask

  // One complete single-block read of tx with the expected outcome.
  task automatic run_block(input string tag, input bit w, input int flip_line,
                           input logic end_v, input logic [3:0] start_v, input logic [4:0] e);
    int base, d0;
    base = got.size(); d0 = done_cnt;
    exp_q.delete(); add_exp();
    do_start(tx.size(), w);
    send_frame(w, flip_line, end_v, start_v);
    repeat (4) @(posedge clk); #1;
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " busy"}, busy, 0);
    check_errs(tag, e);
    check_words(tag, base);
  endtask

  initial begin
    int base, d0, n, len, fl;
    bit w;
    logic ev;

    repeat (3) @(posedge clk); #1;
    resetn = 1'b1;
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset done", done, 0);
    check("reset out_data", out_data, 0);
    check_errs("reset", 5'b00000);

    // 1-line, 512 bytes of 0xFF
    tx.delete();
    repeat (512) tx.push_back(8'hFF);
    run_block("ff512", 1'b0, -1, 1'b1, 4'h0, 5'b00000);

    // 4-line fixed pattern, then the same with a dat2 CRC bit flipped
    tx = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    run_block("wide8", 1'b1, -1, 1'b1, 4'h0, 5'b00000);
    run_block("wide8 crcflip", 1'b1, 2, 1'b1, 4'h0, 5'b10000);

    // Start bit with dat1 high in 4-line mode: flagged, data still received
    tx.delete();
    repeat (8) tx.push_back(8'($urandom_range(0, 255)));
    run_block("startbit", 1'b1, -1, 1'b1, 4'b0010, 5'b00100);

    // Overrun: 32 words into a 16-deep FIFO with nobody popping
    tx.delete();
    repeat (128) tx.push_back(8'($urandom_range(0, 255)));
    exp_q.delete(); add_exp();
    while (exp_q.size() > FD) void'(exp_q.pop_back());
    base = got.size(); d0 = done_cnt;
    out_ready = 1'b0;
    do_start(128, 1'b1);
    send_frame(1'b1, -1, 1'b1, 4'h0);
    check("ovr done pulses", done_cnt - d0, 1);
    check_errs("ovr", 5'b00001);
    out_ready = 1'b1;
    repeat (40) @(posedge clk); #1;
    check_words("ovr", base);
    check("ovr drained", out_valid, 0);

    // Timeout with lines held high
    d0 = done_cnt; n = 0;
    do_start(8, 1'b0);
    while (done_cnt == d0 && n < 200) begin
      sd_tick(4'hF);
      n++;
    end
    check("tmo latency in window", (n >= TO && n <= TO + 2), 1);
    check_errs("tmo", 5'b00010);
    check("tmo out_valid", out_valid, 0);
    check("tmo busy", busy, 0);

    // Abort in the middle of DATA with one word already queued
    tx.delete();
    repeat (8) tx.push_back(8'($urandom_range(0, 255)));
    exp_q.delete(); add_exp();
    out_ready = 1'b0; d0 = done_cnt;
    do_start(8, 1'b1);
    sd_tick(4'hF); sd_tick(4'h0);
    for (int t = 0; t < 10; t++) sd_tick((t % 2 == 0) ? tx[t / 2][7:4] : tx[t / 2][3:0]);
    check("abort pre out_valid", out_valid, 1);
    check("abort pre out_data", out_data, exp_q[0]);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort out_valid", out_valid, 0);
    // abort beats a simultaneous start_req
    abort = 1'b1; start_req = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start_req = 1'b0;
    check("abort over start busy", busy, 0);
    repeat (4) sd_tick(4'hF);
    check("abort no done", done_cnt - d0, 0);
    check_errs("abort", 5'b00000);
    out_ready = 1'b1;

    // Randomized blocks
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      w   = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w ? 3 : 0)) : -1;
      ev  = ($urandom_range(0, 4) != 0);
      tx.delete();
      repeat (len) tx.push_back(8'($urandom_range(0, 255)));
      run_block("rand", w, fl, ev, 4'h0, {fl >= 0, !ev, 3'b000});
    end

`ifdef SD_DAT_MULTI_BLOCK_EN
    // Three 4-byte blocks, second end bit bad
    base = got.size(); d0 = done_cnt;
    block_count = 16'd3;
    exp_q.delete();
    w = 1'($urandom_range(0, 1));
    do_start(4, w);
    for (int b = 0; b < 3; b++) begin
      tx.delete();
      repeat (4) tx.push_back(8'($urandom_range(0, 255)));
      begin
        logic [31:0] keep[$];
        keep = exp_q;
        exp_q.delete(); add_exp();
        exp_q = {keep, exp_q};
      end
      send_frame(w, -1, (b == 1) ? 1'b0 : 1'b1, 4'h0);
      if (b == 0) check("multi no early done", done_cnt - d0, 0);
    end
    repeat (4) @(posedge clk); #1;
    check("multi done pulses", done_cnt - d0, 1);
    check_errs("multi", 5'b01000);
    check_words("multi", base);
    block_count = 16'd1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_dat_reader.md
Name: sd_dat_reader

Overview:
Receives SD data blocks on 1 or 4 DAT lines and checks the per-line CRC16 and end bits. Packs the payload into 32-bit words and pushes them into an internal FIFO, which the AXI side drains through a valid/ready port. Sits beside the command engine in the SD host. Consumes already-sampled DAT levels and the one-per-bus-clock new_sd_clk strobe from the shared pad/clock logic.

Parameters:
NUM_LINES, 4, physical DAT lines (legal: 1 or 4); 4-line operation is only possible at 4
MAX_BLOCK_BYTES, 512, largest block length; sets the width of block_len and the internal byte counter as clog2(MAX_BLOCK_BYTES+1)
FIFO_DEPTH, 16, output FIFO depth in 32-bit words; power of 2, at least 2
TIMEOUT_CLKS, 65536, bus clocks allowed between start_req and the start bit

Ports:
clk  in  1  system clock
resetn  in  1  reset; synchronous, active-low
dat_in  in  NUM_LINES  sampled DAT levels, valid when new_sd_clk=1
new_sd_clk  in  1  1-clk strobe, once per bus clock
start_req  in  1  begin reading one block (or a sequence of blocks); ignored while busy
abort  in  1  cancel the read and flush the FIFO
wide_mode  in  1  1 = use 4 lines; ignored (treated as 0) when NUM_LINES=1
block_len  in  clog2(MAX_BLOCK_BYTES+1)  payload bytes per block; legal range 1..MAX_BLOCK_BYTES; sampled at start_req
out_data  out  32  FIFO head word; first byte of the block in [31:24]
out_valid  out  1  FIFO not empty
out_ready  in  1  pop the head word when out_valid=1
busy  out  1  state != IDLE
done  out  1  1-clk pulse when the read finishes
err_crc, err_end_bit, err_start_bit, err_timeout, err_overrun  out  1 each  error flags for the last read

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0.
- Active lines L:
  - L=4 if wide_mode=1 and NUM_LINES=4.
  - Otherwise L=1, using dat_in[0] only.
- All state advances below are qualified by new_sd_clk, except COLLECT, which lasts exactly one clk.
- On start_req accepted in IDLE:
  - Latch block_len and wide_mode.
  - Clear all err_* flags.
  - Go to WAIT_START.
- WAIT_START:
  - If dat_in[0]=0, go to DATA and reset all CRCs.
  - If L=4 and any of dat_in[3:1]=1 in that same bus clock, set err_start_bit; reception continues.
  - After TIMEOUT_CLKS bus clocks with no start bit, set err_timeout and go to COLLECT.
- DATA:
  - Each bus clock shifts L bits MSB-first. For L=4, the nibble is {dat3,dat2,dat1,dat0} and the high nibble of each byte arrives first.
  - Each line feeds its own CRC16 (polynomial 0x1021, initial value 0).
  - Bytes are packed big-endian into a word.
  - The word is pushed when it holds 4 bytes, or after the final byte. A partial final word has the valid bytes in the MSBs and zeros below.
  - Leave DATA after block_len*8/L bus clocks.
  - If block_len*8 is not divisible by L, the last nibble is truncated (block_len is always an integer number of bytes, so for L=4 it always divides).
- CRC: 16 bus clocks. Received CRC bits are shifted into each line's CRC register. At the end of the state each line's register must be 0; if not, set err_crc.
- END_BIT: 1 bus clock. Any active line at 0 sets err_end_bit. Then go to COLLECT.
- COLLECT: 1 clk. Pulse done, then return to IDLE. Error flags hold their values until the next accepted start_req.
- FIFO:
  - A push while the FIFO is full drops the word and sets err_overrun. Reception continues; CRC is still checked.
  - A push and a pop in the same clk when the FIFO is full: the pop happens first and the push succeeds, with no overrun.
  - Read and write pointers carry an extra wrap bit; full/empty are decided from pointer equality plus the wrap bit.
- abort (any state):
  - Next clk: state IDLE, FIFO emptied, no done pulse, err_* unchanged.
  - abort has priority over a simultaneous start_req.
- Output word order equals arrival order. out_data is registered and updates on the clk after a pop.

Optional Feature:
SD_DAT_MULTI_BLOCK_EN:
- When defined, adds an input block_count [15:0] (latched at start_req; 0 is treated as 1).
- After each END_BIT the block returns to WAIT_START for the next block, with the timeout counter restarted, until block_count blocks have been received.
- Error flags accumulate (OR) across blocks.
- done pulses once, after the last block; a timeout ends the whole sequence.
- When not defined, every read is a single block and the port does not exist.

Test Plan:
- L=1, block_len=512, 512×0xFF, CRC 0x7FA1, end bit 1, out_ready=1 → 128 words of 0xFFFFFFFF; done pulse; all err_*=0.
- L=4, block_len=8, payload 01 23 45 67 89 AB CD EF, per-line CRCs from the bench model → words 0x01234567, 0x89ABCDEF; no errors.
- Same as the previous case with one bit of the dat2 CRC flipped → data words unchanged; err_crc=1, err_end_bit=0.
- FIFO_DEPTH=16, out_ready=0, block_len=128 (32 words) → words 0..15 retained and read back in order; err_overrun=1; done still pulses.
- Lines held high, TIMEOUT_CLKS=64 → done 65±1 bus clocks after start, err_timeout=1, FIFO empty; abort mid-DATA → busy=0 the next clk, out_valid=0, no done.
- With SD_DAT_MULTI_BLOCK_EN, block_count=3, block_len=4 → 3 words out, exactly one done pulse; end bit of block 2 forced 0 → err_end_bit=1 at done.
